// File: rtl/seg7_display_ctrl.sv
// Hex seven-segment display controller. It drives captured nibbles either statically (one pin group per digit)
// or multiplexed (one shared bus plus digit enables). It supports blank/blink masks and leading-zero suppression.

module seg7_digit (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       dark,
  output logic [6:0] seg,
  output logic       dp_on
);
  logic [6:0] hex;

  always_comb begin
    case (nib)
      4'h0:    hex = 7'h3F;
      4'h1:    hex = 7'h06;
      4'h2:    hex = 7'h5B;
      4'h3:    hex = 7'h4F;
      4'h4:    hex = 7'h66;
      4'h5:    hex = 7'h6D;
      4'h6:    hex = 7'h7D;
      4'h7:    hex = 7'h07;
      4'h8:    hex = 7'h7F;
      4'h9:    hex = 7'h6F;
      4'hA:    hex = 7'h77;
      4'hB:    hex = 7'h7C;
      4'hC:    hex = 7'h39;
      4'hD:    hex = 7'h5E;
      4'hE:    hex = 7'h79;
      default: hex = 7'h71;
    endcase
  end

  assign seg   = dark ? 7'h00 : hex;
  assign dp_on = dp & ~dark;
endmodule

module seg7_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 24,
  parameter int SCAN_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  load,
  input  logic                  lz_suppress,
  output logic [7*DIGITS-1:0]   segs,
  output logic [DIGITS-1:0]     dps,
  output logic [6:0]            mux_seg,
  output logic                  mux_dp,
  output logic [DIGITS-1:0]     mux_en,
  output logic                  blink_phase
);
  localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic OFF   = 1'(ACTIVE_LOW != 0);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] value;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0]      blink;
  } disp_cfg_t;

  disp_cfg_t              cfg_r, cfg_in;
  logic [BLINK_DIV-1:0]   blink_cnt;
  logic [SCAN_DIV-1:0]    scan_cnt;
  logic [IDX_W-1:0]       scan_idx;

  logic [DIGITS-1:0][3:0] nib_r;
  logic [DIGITS-1:0]      dp_r;
  logic [DIGITS-1:0]      dark;
  logic [DIGITS-1:0][6:0] seg_on;
  logic [DIGITS-1:0]      dp_on;

  logic [6:0]             sel_seg;
  logic                   sel_dp;
  logic [DIGITS-1:0]      sel_en;

  assign cfg_in = {value_in, dp_in, blank_in, blink_in};
  assign nib_r  = cfg_r.value;
  assign dp_r   = cfg_r.dp;

  // The zero run is scanned from the top digit down. Digit 0 is never suppressed, so a value of zero still shows "0".
  always_comb begin
    logic run;
    run  = 1'b1;
    dark = '0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      run     = run & (cfg_r.value[k] == 4'h0);
      dark[k] = cfg_r.blank[k] | (cfg_r.blink[k] & blink_phase) |
                (lz_suppress & run & (k != 0));
    end
  end

  seg7_digit u_digit [DIGITS-1:0] (
    .nib   (nib_r),
    .dp    (dp_r),
    .dark  (dark),
    .seg   (seg_on),
    .dp_on (dp_on)
  );

  // The enable is held off for the first cycle of each slot. This lets the shared bus settle before the next digit lights.
  always_comb begin
    sel_seg = '0;
    sel_dp  = 1'b0;
    sel_en  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        sel_seg   = seg_on[k];
        sel_dp    = dp_on[k];
        sel_en[k] = (scan_cnt != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      cfg_r.value <= '0;
      cfg_r.dp    <= '0;
      cfg_r.blank <= '1;
      cfg_r.blink <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      segs        <= {(7*DIGITS){OFF}};
      dps         <= {DIGITS{OFF}};
      mux_seg     <= {7{OFF}};
      mux_dp      <= OFF;
      mux_en      <= {DIGITS{OFF}};
    end else begin
      if (load) cfg_r <= cfg_in;
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) blink_phase <= ~blink_phase;
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt)
        scan_idx <= (scan_idx == IDX_W'(DIGITS-1)) ? '0 : scan_idx + 1'b1;
      segs    <= seg_on ^ {(7*DIGITS){OFF}};
      dps     <= dp_on ^ {DIGITS{OFF}};
      mux_seg <= sel_seg ^ {7{OFF}};
      mux_dp  <= sel_dp ^ OFF;
      mux_en  <= sel_en ^ {DIGITS{OFF}};
    end
  end
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench with two configurations. One is 4-digit active-low with fast blink; the other is 3-digit active-high with fast scan.
// Expected values are queued with a target cycle, and a negedge monitor pops and compares them.

module tb_seg7_display_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: DIGITS=4, ACTIVE_LOW=1, BLINK_DIV=3, SCAN_DIV=2
  logic        rst_a, load_a, lz_a;
  logic [15:0] val_a;
  logic [3:0]  dp_a, blank_a, blink_a;
  logic [27:0] segs_a;
  logic [3:0]  dps_a, mux_en_a;
  logic [6:0]  mux_seg_a;
  logic        mux_dp_a, bp_a;

  // DUT B: DIGITS=3, ACTIVE_LOW=0, BLINK_DIV=3, SCAN_DIV=2
  logic        rst_b, load_b, lz_b;
  logic [11:0] val_b;
  logic [2:0]  dp_b, blank_b, blink_b;
  logic [20:0] segs_b;
  logic [2:0]  dps_b, mux_en_b;
  logic [6:0]  mux_seg_b;
  logic        mux_dp_b, bp_b;

  seg7_display_ctrl #(.DIGITS(4), .ACTIVE_LOW(1), .BLINK_DIV(3), .SCAN_DIV(2)) dut_a (
    .clk(clk), .reset_in(rst_a), .value_in(val_a), .dp_in(dp_a), .blank_in(blank_a),
    .blink_in(blink_a), .load(load_a), .lz_suppress(lz_a), .segs(segs_a), .dps(dps_a),
    .mux_seg(mux_seg_a), .mux_dp(mux_dp_a), .mux_en(mux_en_a), .blink_phase(bp_a)
  );

  seg7_display_ctrl #(.DIGITS(3), .ACTIVE_LOW(0), .BLINK_DIV(3), .SCAN_DIV(2)) dut_b (
    .clk(clk), .reset_in(rst_b), .value_in(val_b), .dp_in(dp_b), .blank_in(blank_b),
    .blink_in(blink_b), .load(load_b), .lz_suppress(lz_b), .segs(segs_b), .dps(dps_b),
    .mux_seg(mux_seg_b), .mux_dp(mux_dp_b), .mux_en(mux_en_b), .blink_phase(bp_b)
  );

  localparam int S_SEGS_A = 0, S_DPS_A = 1, S_BP_A = 2, S_EN_A = 3, S_MSEG_A = 4;
  localparam int S_SEGS_B = 5, S_EN_B = 6, S_MSEG_B = 7;

  localparam logic [2:0] EN_TAB  [13] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd2,
                                          3'd0, 3'd4, 3'd4, 3'd4, 3'd0};
  localparam logic [6:0] SEG_TAB [14] = '{7'h00, 7'h07, 7'h07, 7'h07, 7'h39, 7'h39, 7'h39,
                                          7'h39, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h07, 7'h07};

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input int c, input int sel, input logic [31:0] e, input string n);
    chk_t t;
    t.cyc = c; t.sel = sel; t.exp = e; t.name = n;
    sb.push_back(t);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [31:0] act(input int sel);
    case (sel)
      S_SEGS_A: return {4'h0, segs_a};
      S_DPS_A:  return {28'h0, dps_a};
      S_BP_A:   return {31'h0, bp_a};
      S_EN_A:   return {28'h0, mux_en_a};
      S_MSEG_A: return {25'h0, mux_seg_a};
      S_SEGS_B: return {11'h0, segs_b};
      S_EN_B:   return {29'h0, mux_en_b};
      S_MSEG_B: return {25'h0, mux_seg_b};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] a;
        a = act(sb[i].sel);
        n_tests++;
        if (a !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, a, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    wait_cyc(2);
    n_tests++;
    if (segs_a !== 28'hFFFFFFF) begin
      n_fail++;
      $display("FAIL direct reset segs: got %h", segs_a);
    end
    wait_cyc(34);
    n_tests++;
    if (segs_a !== {7'h00, 7'h08, 7'h79, 7'h40}) begin
      n_fail++;
      $display("FAIL direct decode 8A10: got %h", segs_a);
    end
    wait_cyc(38);
    n_tests++;
    if (segs_a !== {7'h7F, 7'h7F, 7'h12, 7'h40}) begin
      n_fail++;
      $display("FAIL direct lz 0050: got %h", segs_a);
    end
    wait_cyc(45);
    n_tests++;
    if (dps_a !== 4'b1011) begin
      n_fail++;
      $display("FAIL direct dp2 on: got %b", dps_a);
    end
  end

  // DUT A timeline
  initial begin
    rst_a = 1'b0; load_a = 1'b0; lz_a = 1'b0;
    val_a = '0; dp_a = '0; blank_a = '0; blink_a = '0;
    chk(2, S_SEGS_A, 28'hFFFFFFF, "a reset segs");
    chk(2, S_DPS_A,  4'hF,        "a reset dps");
    chk(2, S_EN_A,   4'hF,        "a reset mux_en");
    chk(2, S_MSEG_A, 7'h7F,       "a reset mux_seg");
    chk(2, S_BP_A,   1'b0,        "a reset blink_phase");
    wait_cyc(1); load_a = 1'b1; val_a = 16'h8A10;
    chk(3, S_SEGS_A, 28'hFFFFFFF, "a load during reset");
    wait_cyc(2); load_a = 1'b0;
    wait_cyc(4); rst_a = 1'b1;
    chk(5, S_SEGS_A, 28'hFFFFFFF, "a dark after release");
    chk(6, S_SEGS_A, 28'hFFFFFFF, "a dark until load");
    chk(5, S_EN_A,   4'hF,        "a mux_en dead cycle");
    chk(6, S_EN_A,   4'hE,        "a mux_en digit0");
    // blink: release at cyc 4, toggles at edges 12, 20, 28; segs lag by one
    wait_cyc(6); load_a = 1'b1; val_a = 16'h0001; blink_a = 4'b0001;
    chk(8,  S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h79}, "a blink lit first");
    chk(11, S_BP_A, 1'b0, "a bp before toggle");
    chk(12, S_BP_A, 1'b1, "a bp toggle 1");
    chk(12, S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h79}, "a blink lag lit");
    chk(13, S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h7F}, "a blink dark");
    chk(19, S_BP_A, 1'b1, "a bp held");
    chk(20, S_BP_A, 1'b0, "a bp toggle 2");
    chk(20, S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h7F}, "a blink dark end");
    chk(21, S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h79}, "a blink relit");
    chk(28, S_BP_A, 1'b1, "a bp toggle 3");
    chk(29, S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h7F}, "a blink dark again");
    wait_cyc(7); load_a = 1'b0;

    wait_cyc(32); load_a = 1'b1; val_a = 16'h8A10; blink_a = 4'b0000;
    chk(34, S_SEGS_A, {7'h00, 7'h08, 7'h79, 7'h40}, "a decode 8A10");
    wait_cyc(33); load_a = 1'b0;
    wait_cyc(36); load_a = 1'b1; val_a = 16'h0050; lz_a = 1'b1;
    chk(38, S_SEGS_A, {7'h7F, 7'h7F, 7'h12, 7'h40}, "a lz 0050");
    wait_cyc(37); load_a = 1'b0;
    wait_cyc(40); load_a = 1'b1; val_a = 16'h0000; dp_a = 4'b0100;
    chk(42, S_SEGS_A, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "a lz 0000");
    chk(42, S_DPS_A, 4'hF, "a lz hides dp");
    wait_cyc(41); load_a = 1'b0;
    wait_cyc(44); lz_a = 1'b0;
    chk(45, S_SEGS_A, {7'h40, 7'h40, 7'h40, 7'h40}, "a lz level off");
    chk(45, S_DPS_A, 4'b1011, "a dp2 on");
    wait_cyc(46); load_a = 1'b1; blank_a = 4'b0100;
    chk(48, S_SEGS_A, {7'h40, 7'h7F, 7'h40, 7'h40}, "a blank digit2");
    chk(48, S_DPS_A, 4'hF, "a blank hides dp");
    wait_cyc(47); load_a = 1'b0;
    wait_cyc(50); load_a = 1'b1; val_a = 16'h1000; dp_a = '0; blank_a = '0; lz_a = 1'b1;
    chk(52, S_SEGS_A, {7'h79, 7'h40, 7'h40, 7'h40}, "a lz inner zeros");
    wait_cyc(51); load_a = 1'b0;
    // load held high: captures every edge
    wait_cyc(56); load_a = 1'b1; val_a = 16'h346B;
    chk(58, S_SEGS_A, {7'h30, 7'h19, 7'h02, 7'h03}, "a decode 346B");
    chk(59, S_SEGS_A, {7'h30, 7'h19, 7'h02, 7'h03}, "a decode 346B hold");
    wait_cyc(58); val_a = 16'h9D6F;
    chk(60, S_SEGS_A, {7'h10, 7'h21, 7'h02, 7'h0E}, "a decode 9D6F");
    wait_cyc(59); load_a = 1'b0;
    wait_cyc(62); rst_a = 1'b0; load_a = 1'b1; val_a = 16'hFFFF;
    chk(62, S_BP_A, 1'b1, "a bp before mid reset");
    chk(63, S_SEGS_A, 28'hFFFFFFF, "a mid reset segs");
    chk(63, S_BP_A, 1'b0, "a mid reset bp");
    chk(63, S_EN_A, 4'hF, "a mid reset mux_en");
    chk(64, S_SEGS_A, 28'hFFFFFFF, "a reset ignores load");
  end

  // DUT B timeline: release at cyc 4, scan slots of 4 cycles over 3 digits
  initial begin
    rst_b = 1'b0; load_b = 1'b0; lz_b = 1'b0;
    val_b = '0; dp_b = '0; blank_b = '0; blink_b = '0;
    chk(2, S_SEGS_B, 21'h0, "b reset segs");
    chk(2, S_EN_B,   3'h0,  "b reset mux_en");
    chk(2, S_MSEG_B, 7'h00, "b reset mux_seg");
    wait_cyc(4); rst_b = 1'b1; load_b = 1'b1; val_b = 12'h2C7;
    for (int k = 0; k < 13; k++) chk(5 + k, S_EN_B, {29'h0, EN_TAB[k]}, "b mux_en scan");
    for (int k = 0; k < 14; k++) chk(5 + k, S_MSEG_B, {25'h0, SEG_TAB[k]}, "b mux_seg scan");
    wait_cyc(5); load_b = 1'b0;
    wait_cyc(20); load_b = 1'b1; val_b = 12'h0E5;
    chk(21, S_EN_B,   3'b000, "b mid load en pre");
    chk(21, S_MSEG_B, 7'h39,  "b mid load seg pre");
    chk(22, S_EN_B,   3'b010, "b mid load en");
    chk(22, S_MSEG_B, 7'h79,  "b mid load seg");
    chk(22, S_SEGS_B, {7'h3F, 7'h79, 7'h6D}, "b static segs");
    chk(23, S_EN_B,   3'b010, "b scan undisturbed");
    chk(25, S_EN_B,   3'b000, "b slot2 dead");
    chk(25, S_MSEG_B, 7'h3F,  "b slot2 seg");
    chk(26, S_EN_B,   3'b100, "b slot2 en");
    wait_cyc(21); load_b = 1'b0;
  end

  initial begin
    wait_cyc(70);
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: check for cyc %0d never ran", sb[i].name, sb[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
